// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - Request, divider and result handshakes around div_issue_ctrl
interface div_issue_ctrl_if #(parameter int N_BITS = 32);
   logic              op_valid_i;
   logic              op_ready_o;
   logic [N_BITS-1:0] op_a_i;
   logic [N_BITS-1:0] op_b_i;
   logic              op_rem_i;
   logic [N_BITS-1:0] div_a_o;
   logic [N_BITS-1:0] div_b_o;
   logic              div_en_o;
   logic              div_ready_o;
   logic [N_BITS-1:0] div_q_i;
   logic [N_BITS-1:0] div_r_i;
   logic              div_valid_i;
   logic              res_valid_o;
   logic              res_ready_i;
   logic [N_BITS-1:0] res_data_o;
   logic              res_dbz_o;
   logic              err_o;

   // master: the controller; slave: PE datapath, divider and result consumer
   modport master (
      input  op_valid_i, op_a_i, op_b_i, op_rem_i, div_q_i, div_r_i, div_valid_i, res_ready_i,
      output op_ready_o, div_a_o, div_b_o, div_en_o, div_ready_o, res_valid_o, res_data_o,
             res_dbz_o, err_o
   );
   modport slave (
      output op_valid_i, op_a_i, op_b_i, op_rem_i, div_q_i, div_r_i, div_valid_i, res_ready_i,
      input  op_ready_o, div_a_o, div_b_o, div_en_o, div_ready_o, res_valid_o, res_data_o,
             res_dbz_o, err_o
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - Credit-bounded issue/collect controller for a pipelined divider
// Optional macro DIV_DBZ_OVERRIDE_EN: divide-by-zero results replaced by -1 / dividend.
module div_issue_ctrl #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   div_issue_ctrl_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef DIV_DBZ_OVERRIDE_EN
   localparam int TW = N_BITS + 2;
`else
   localparam int TW = 1;
`endif

   logic [CW-1:0]   used;
   logic [TW-1:0]   tag_mem [DEPTH];
   logic [AW-1:0]   tag_wr, tag_rd;
   logic [CW-1:0]   tag_cnt;
   logic [N_BITS:0] res_mem [DEPTH];
   logic [AW-1:0]   res_wr, res_rd;
   logic [CW-1:0]   res_cnt;
   logic [TW-1:0]   tag_in, tag_head;
   logic [N_BITS-1:0] sel_data;
   logic            sel_dbz;
   logic            accept, pop, tag_empty, tag_pop;

   assign bus.op_ready_o  = (used < CW'(DEPTH)) & ~rst_i;
   assign bus.div_ready_o = ~rst_i;
   assign accept    = bus.op_valid_i & bus.op_ready_o;
   assign pop       = bus.res_valid_o & bus.res_ready_i;
   assign tag_empty = (tag_cnt == '0);
   assign tag_pop   = bus.div_valid_i & ~tag_empty;
   assign tag_head  = tag_mem[tag_rd];

`ifdef DIV_DBZ_OVERRIDE_EN
   assign tag_in = {bus.op_rem_i, bus.op_b_i == '0, bus.op_a_i};
   always_comb begin
      sel_dbz = tag_head[N_BITS];
      if (sel_dbz)
         sel_data = tag_head[N_BITS+1] ? tag_head[N_BITS-1:0] : '1;
      else
         sel_data = tag_head[N_BITS+1] ? bus.div_r_i : bus.div_q_i;
   end
`else
   assign tag_in   = bus.op_rem_i;
   assign sel_dbz  = 1'b0;
   assign sel_data = tag_head[0] ? bus.div_r_i : bus.div_q_i;
`endif

   // Empty FIFO reads as zero so the result outputs show reset values
   assign bus.res_valid_o = (res_cnt != '0);
   assign bus.res_data_o  = bus.res_valid_o ? res_mem[res_rd][N_BITS-1:0] : '0;
   assign bus.res_dbz_o   = bus.res_valid_o & res_mem[res_rd][N_BITS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         used         <= '0;
         tag_wr       <= '0;
         tag_rd       <= '0;
         tag_cnt      <= '0;
         res_wr       <= '0;
         res_rd       <= '0;
         res_cnt      <= '0;
         bus.div_en_o <= 1'b0;
         bus.div_a_o  <= '0;
         bus.div_b_o  <= '0;
         bus.err_o    <= 1'b0;
      end else begin
         if (accept & ~pop)
            used <= used + CW'(1);
         else if (pop & ~accept)
            used <= used - CW'(1);
         if (accept)
            tag_wr <= tag_wr + AW'(1);
         if (tag_pop)
            tag_rd <= tag_rd + AW'(1);
         tag_cnt <= tag_cnt + CW'(accept) - CW'(tag_pop);
         if (tag_pop)
            res_wr <= res_wr + AW'(1);
         if (pop)
            res_rd <= res_rd + AW'(1);
         res_cnt <= res_cnt + CW'(tag_pop) - CW'(pop);
         bus.div_en_o <= accept;
         if (accept) begin
            bus.div_a_o <= bus.op_a_i;
            bus.div_b_o <= bus.op_b_i;
         end
         if (bus.div_valid_i & tag_empty)
            bus.err_o <= 1'b1;
      end
   end

   // Credits keep both FIFOs from overflowing, so no full checks are needed
   always_ff @(posedge clk_i) begin
      if (accept)
         tag_mem[tag_wr] <= tag_in;
      if (tag_pop)
         res_mem[res_wr] <= {sel_dbz, sel_data};
   end
endmodule
